// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// State encodings, state width and the default memory wait limit.
package cpu_seq_pkg;

  localparam int ST_W = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_HALT  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_DEC   = 3'd2;
  localparam state_t S_EXEC  = 3'd3;
  localparam state_t S_MEM   = 3'd4;
  localparam state_t S_WB    = 3'd5;
  localparam state_t S_ERROR = 3'd6;

  localparam int MEM_WAIT_MAX_DEF = 15;

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Memory wait-state counter shared by FETCH and MEM.
// Ports: clk, rst (sync, active-low), clr, inc in; expired out.
module mem_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW =
    (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(MEM_WAIT_MAX));

  // Hold at the limit; the sequencer leaves the
  // waiting state on the same edge anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with debug control.
// Ports: run/step/halt_req, dec_* and mem_ready in; enables, status, retired out.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             dec_RegWE,
  input  logic             dec_MemWE,
  input  logic             dec_load,
  input  logic             illegal,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_we,
  output logic             halted,
  output logic             err,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic             single_q, single_d;
  logic             hpend_q, hpend_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic step_rise;
  logic in_wait;
  logic expired;
  logic stop_wb;

  assign step_rise = step & ~step_q;
  assign step_d    = step;

  assign in_wait = (state_q == S_FETCH) ||
                   (state_q == S_MEM);

  // Counter is held clear outside FETCH/MEM, so it
  // starts at zero on every entry.
  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_wait),
    .inc    (in_wait & ~mem_ready),
    .expired(expired)
  );

  // A halt_req seen in WB itself still stops at this boundary.
  assign stop_wb = single_q | hpend_q |
                   halt_req | ~run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_HALT;
      step_q   <= 1'b0;
      single_q <= 1'b0;
      hpend_q  <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      single_q <= single_d;
      hpend_q  <= hpend_d;
      ret_q    <= ret_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    hpend_d  = hpend_q |
               (halt_req && state_q != S_HALT);
    ret_d    = ret_q;
    unique case (state_q)
      S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
        end else if (step_rise) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_ready)
          state_d = S_DEC;
        else if (expired)
          state_d = S_ERROR;
      end
      S_DEC: begin
        state_d = illegal ? S_ERROR : S_EXEC;
      end
      S_EXEC: begin
        state_d = (dec_load || dec_MemWE) ?
                  S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = S_WB;
        else if (expired)
          state_d = S_ERROR;
      end
      S_WB: begin
        state_d  = stop_wb ? S_HALT : S_FETCH;
        single_d = 1'b0;
        hpend_d  = 1'b0;
        ret_d    = ret_q + CNT_W'(1);
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_HALT: begin
        halted = 1'b1;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_MemWE;
      end
      S_WB: begin
        reg_we = dec_RegWE;
        pc_en  = 1'b1;
      end
      S_ERROR: begin
        halted = 1'b1;
        err    = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign state   = state_q;
  assign retired = ret_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RISC-V core datapath (PC, instruction memory, ID, register file, branch compare, EX). It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and generates the per-phase enables:
- PC update
- instruction-register capture
- register-file write
- data-memory write

It also supports run/halt/single-step debug control, memory wait states with timeout, and a retired-instruction counter. It sits beside ID and drives the enables that ID's raw decode outputs are currently wired to directly.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory request may wait for mem_ready before ERROR.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- run  in  1  level; 1 = free-run instructions back to back.
- step  in  1  single-step request; rising edge detected internally.
- halt_req  in  1  request to stop at the next instruction boundary.
- dec_RegWE  in  1  from ID: instruction writes rd.
- dec_MemWE  in  1  from ID: instruction is a store.
- dec_load  in  1  from ID: instruction is a load (WBSel selects memory).
- illegal  in  1  from ID: undecodable instruction.
- mem_ready  in  1  memory handshake completion for the current request.
- mem_req  out  1  memory request (FETCH and MEM states).
- ir_en  out  1  capture instruction word.
- pc_en  out  1  PC register load enable.
- reg_we  out  1  register-file write enable.
- mem_we  out  1  data-memory write enable.
- halted  out  1  1 in HALT or ERROR.
- err  out  1  sticky error flag.
- state  out  3  current state encoding.
- retired  out  CNT_W  count of completed instructions.

## Operation
State encoding:
- HALT=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, ERROR=6.
- 7 is unused; if reached, the next state is ERROR.

Transitions:
- HALT: run=1 -> FETCH. Otherwise a step rising edge -> FETCH and sets the single flag.
- FETCH: mem_req=1. On mem_ready -> DECODE with ir_en=1 for that cycle.
- DECODE: illegal=1 -> ERROR; otherwise -> EXECUTE.
- EXECUTE: dec_load or dec_MemWE -> MEM; otherwise -> WB.
- MEM: mem_req=1, and mem_we=dec_MemWE while waiting. On mem_ready -> WB.
- WB: reg_we=dec_RegWE for one cycle; pc_en=1 for one cycle; retired increments. Next state is HALT if any of single, halt_pending or !run is set; otherwise FETCH. single and halt_pending clear in WB.
- ERROR: halted=1, err=1. All enables stay 0 until reset.

Rules:
- halt_req in any non-HALT state sets halt_pending. The current instruction always completes.
- step edges outside HALT are ignored.
- Wait timeout: wait_cnt clears on entry to FETCH/MEM and increments each cycle without mem_ready. If wait_cnt==MEM_WAIT_MAX with mem_ready=0 -> ERROR. A mem_ready arriving in that same cycle wins.
- retired wraps modulo 2^CNT_W.
- All outputs not listed for a state are 0.

## Timing
- Outputs are combinational from the registered state plus dec_*/mem_ready. They are glitch-free relative to clk.
- Reset (rst=0 at an edge) values:
  - state=HALT; retired=0; err=0; halted=1.
  - single, halt_pending, wait_cnt, and the step edge register all cleared.
  - All enables 0.
- Reset takes priority over every transition, including mid-MEM. No partial pc_en or reg_we may be issued.
- Latency with zero-wait memory:
  - ALU/branch instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- From HALT, run=1 sampled at edge N puts the sequencer in FETCH in cycle N+1.

## Structure
- Shared package cpu_seq_pkg holds:
  - state localparams (HALT..ERROR) and their 3-bit width;
  - default MEM_WAIT_MAX.
- One sub-module, mem_wait_timer: clear, count, and an expired flag parameterised by MEM_WAIT_MAX. It is used by FETCH and MEM.
- State register, step edge detector, flags, and retired counter live in cpu_sequencer.

## Test plan
- Reset then run=1, mem_ready=1, ALU instruction with dec_RegWE=1 -> states 1,2,3,5,1. reg_we and pc_en each high exactly 1 cycle. retired=1 after 4 cycles.
- Store with dec_MemWE=1, mem_ready delayed 3 cycles in MEM -> mem_we high 4 cycles, reg_we=0, total 8 cycles, retired increments once.
- run=0, two step pulses 10 cycles apart -> exactly 2 instructions retire. halted=1 between them. A step pulsed mid-instruction is ignored.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> ERROR after 16 cycles, err=1, sticky until rst=0. Repeat with mem_ready=1 at cycle 16 -> DECODE, no error.
- illegal=1 in DECODE -> ERROR next cycle, pc_en never asserted, retired unchanged.
- rst=0 asserted in MEM of a load -> next cycle state=HALT, retired=0, reg_we and pc_en never pulse. Additionally, halt_req pulsed in EXECUTE -> instruction completes and the sequencer returns to HALT after WB.
